uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload width in bits.
REQ-002 Port i_ref_clk  input  1  SHALL be the block clock (bit clock, one UART bit per cycle); all state updates SHALL occur on its rising edge.
REQ-003 Port i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port i_p_data  input  DATA_WIDTH  SHALL be the parallel payload, sampled only on accept.
REQ-005 Port i_data_valid  input  1  SHALL request transmission of i_p_data.
REQ-006 Port i_par_en  input  1  SHALL enable the parity bit (1 = parity bit present), sampled only on accept.
REQ-007 Port i_par_typ  input  1  SHALL select parity type (0 = even, 1 = odd), sampled only on accept.
REQ-008 Port o_tx_out  output  1  SHALL be the serial line, registered, idle-high.
REQ-009 Port o_busy  output  1  SHALL be high while a frame occupies the line, registered.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Accept SHALL occur on a rising edge where i_data_valid=1 and state is IDLE or STOP; on accept, i_p_data, i_par_en and i_par_typ SHALL be latched into internal registers.
REQ-012 i_data_valid in START, DATA or PARITY SHALL be ignored; no queuing; the input value is not retained.
REQ-013 The cycle after accept SHALL be START: o_tx_out=0, o_busy=1.
REQ-014 DATA SHALL last DATA_WIDTH cycles, shifting latched data out LSB first, one bit per cycle; a bit counter of width clog2(DATA_WIDTH) SHALL wrap to 0 on leaving DATA.
REQ-015 After the last data bit, the FSM SHALL enter PARITY if latched par_en=1, else STOP.
REQ-016 Parity bit SHALL be XOR-reduce of latched data for even, inverted for odd.
REQ-017 STOP SHALL last one cycle with o_tx_out=1, o_busy=1.
REQ-018 From STOP: accept -> START next cycle (back-to-back, no idle bit); no accept -> IDLE.
REQ-019 In IDLE, o_tx_out=1 and o_busy=0.
REQ-020 Frame length SHALL be DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity, measured from START through STOP inclusive.
REQ-021 Changes on i_p_data, i_par_en, i_par_typ after accept SHALL NOT affect the frame in progress.
REQ-022 o_tx_out and o_busy SHALL be driven from flops; no combinational path from any input to either output.

Reset
REQ-023 While i_rst=1 at a rising edge: state -> IDLE, o_tx_out -> 1, o_busy -> 0, bit counter and data register -> 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; the line SHALL be 1 from the cycle after the reset edge, and no residual bits SHALL be emitted.
REQ-025 i_data_valid=1 on the same edge as i_rst=1 SHALL be ignored; reset wins.

Verification
REQ-026 i_p_data=0xA5, par_en=1, par_typ=0, valid pulse 1 cycle -> o_tx_out: 0, then 1,0,1,0,0,1,0,1, then 0 (parity), then 1; o_busy high for exactly 11 cycles.
REQ-027 Same payload with par_typ=1 -> parity bit 1; all other bits unchanged from REQ-026.
REQ-028 i_p_data=0x00, par_en=0 -> 0, then eight 0s, then 1; o_busy high for exactly 10 cycles; then o_tx_out=1 and o_busy=0.
REQ-029 Valid held high continuously with 0x3C then 0xC3, par_en=0 -> STOP of frame 1 followed directly by START of frame 2; o_busy never drops between frames; 0xC3 sampled at frame-1 STOP edge.
REQ-030 Valid pulsed with 0xFF during DATA of a 0x12 frame -> 0x12 frame unaffected; 0xFF never transmitted.
REQ-031 i_rst asserted on the 4th data bit of 0x5A -> o_tx_out=1, o_busy=0 on the next cycle; a subsequent valid with 0x81 produces a clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// Serial transmitter: one UART bit per i_ref_clk cycle, optional parity,
// back-to-back frames when a new request arrives during the stop bit.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_ref_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_next_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx_out;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_last_bit;
  logic                  w_parity;
  logic                  w_next_tx;
  logic                  w_next_busy;

  // Outputs are computed for the upcoming state and registered, so the line
  // shows each state's bit during that state with no input-to-output path.
  always_comb begin
    w_accept     = i_data_valid && ((r_state == IDLE) || (r_state == STOP));
    w_last_bit   = (r_cnt == LAST_BIT);
    w_parity     = (^r_data) ^ r_par_typ;
    w_next_state = r_state;
    w_next_cnt   = '0;
    w_next_tx    = 1'b1;
    w_next_busy  = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = START;
        end
      end
      START: begin
        w_next_state = DATA;
      end
      DATA: begin
        if (w_last_bit) begin
          w_next_state = r_par_en ? PARITY : STOP;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        w_next_state = STOP;
      end
      STOP: begin
        w_next_state = w_accept ? START : IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    case (w_next_state)
      IDLE:    w_next_busy = 1'b0;
      START:   w_next_tx   = 1'b0;
      DATA:    w_next_tx   = r_data[w_next_cnt];
      PARITY:  w_next_tx   = w_parity;
      default: w_next_tx   = 1'b1;
    endcase
  end

  // State, payload latch and registered line outputs; reset wins over accept.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_tx_out <= w_next_tx;
      r_busy   <= w_next_busy;
      if (w_accept) begin
        r_data    <= i_p_data;
        r_par_en  <= i_par_en;
        r_par_typ <= i_par_typ;
      end
    end
  end

  assign o_tx_out = r_tx_out;
  assign o_busy   = r_busy;

endmodule
